axil_mem_responder: RTL
=======================

# axil_mem_responder

Memory-side responder for the load/store port used by the CPU's MEM stage. It accepts read-address (AR), read-data (R), write-address (AW), write-data (W) and write-response (B) handshakes, and backs them with an internal word-addressed array. Read latency is configurable. The block replaces the behavioural SRAM model in simulation and doubles as a synthesizable on-chip data RAM.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width; must be 32.
- ADDR_WIDTH, 32, byte-address width.
- DEPTH_LOG2, 12, log2 of the word count (4096 words = 16 KiB).
- RD_LATENCY, 1, cycles from AR handshake to rvalid; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- araddr  in  ADDR_WIDTH  read byte address.
- arvalid  in  1  read request valid.
- arready  out  1  read request accepted.
- rdata  out  DATA_WIDTH  read word.
- rresp  out  2  2'b00 OKAY, 2'b10 SLVERR.
- rvalid  out  1  read data valid.
- rready  in  1  master accepts the read data.
- awaddr  in  ADDR_WIDTH  write byte address.
- awvalid  in  1  write address valid.
- awready  out  1  write address accepted.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  DATA_WIDTH/8  byte enables; bit i enables wdata[8i+7:8i].
- wvalid  in  1  write data valid.
- wready  out  1  write data accepted.
- bresp  out  2  write response, same encoding as rresp.
- bvalid  out  1  write response valid.
- bready  in  1  master accepts the write response.

## Operation
- Word index = addr[DEPTH_LOG2+1:2]. addr[1:0] is ignored; rdata is always the aligned word. The master performs byte and halfword lane extraction and sign extension.
- An address is out of range if any of addr[ADDR_WIDTH-1:DEPTH_LOG2+2] is nonzero.
  - Out-of-range read: rdata=0, rresp=SLVERR.
  - Out-of-range write: no array change, bresp=SLVERR.
- Read FSM:
  - R_IDLE: arready=1. On arvalid&arready, latch the address, load the latency counter, go to R_WAIT.
  - R_WAIT: arready=0. Decrement the counter each cycle. When the counter reaches 0, sample the array into the rdata register and go to R_RESP.
  - R_RESP: rvalid=1. rdata and rresp are held stable until rready. On rvalid&rready, go to R_IDLE.
- Write path: independent flags aw_got and w_got.
  - awready = !aw_got & !bvalid. wready = !w_got & !bvalid.
  - AW and W may arrive in either order or in the same cycle; each is latched on its own handshake.
  - Commit cycle: the first cycle in which both are held. In that cycle, write the enabled bytes, set bvalid, and clear both flags.
  - bvalid holds until bready. No new AW or W is accepted while bvalid=1.
- Read and write are independent and may overlap.
- Collision: if the write commit and the read sample hit the same word in the same cycle, the read returns the old data (read-before-write).
- wstrb=0 commits nothing to the array but still returns bresp=OKAY.

## Timing
- Reset values: arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=2'b00, bresp=2'b00. Both FSMs and flags are cleared.
- Array contents are not reset.
- Asserting reset mid-transaction aborts it immediately. A write whose commit edge has not occurred is not stored.
- Read latency:
  - AR handshake at edge T gives rvalid=1 after edge T+RD_LATENCY.
  - Next AR is accepted no earlier than the edge after the R handshake.
  - Peak throughput is 1 read per RD_LATENCY+2 cycles.
- Write latency: the last of the AW/W handshakes at edge T gives bvalid=1 after edge T+1, with the array already updated.
- rvalid and bvalid never drop without the corresponding ready.

## Configuration
- RAND_DELAY_EN defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) is seeded to 8'hA5 on reset and advances every cycle.
  - Each AR handshake loads the latency counter with 1+lfsr[2:0], giving 1..8 cycles. RD_LATENCY is ignored.
  - Used to stress the MEM-stage stall logic.
- RAND_DELAY_EN undefined: the latency is fixed at RD_LATENCY and the LFSR is not built.

## Test plan
- Reset, then write 0xDEADBEEF to address 0x10 with wstrb=4'hF (AW and W in the same cycle) -> bvalid one cycle later, bresp=00. Read 0x10 with RD_LATENCY=1 -> rdata=0xDEADBEEF, rvalid at T+1.
- Partial write to address 0x10 with wstrb=4'b0010 and wdata=0x0000AA00 -> a read of 0x10 returns 0xDEADAABE... corrected: returns 0xDEADAAEF.
- W two cycles before AW -> wready drops after the W handshake, and bvalid asserts exactly one cycle after the AW handshake.
- Hold rready=0 for 5 cycles -> rvalid, rdata and rresp stay stable, and arready=0 throughout.
- Read of 0x0001_0000 (out of range) -> rresp=10, rdata=0. Write to the same address -> bresp=10, and no array word changes.
- With RAND_DELAY_EN, run 100 reads -> every latency falls in 1..8, and the data matches a reference model.

Source files
------------

// File: rtl/axil_mem_responder.sv
// ---------------------------------------------------------------------------
// axil_mem_responder
//
// Memory-side responder for the CPU MEM-stage load/store port. Serves AXI-Lite
// style AR/R and AW/W/B handshakes from an internal word-addressed array.
// Reads go through a three-state FSM with a programmable latency counter.
// Writes collect AW and W independently and commit one cycle after both are
// held.
//
// Parameters:
//   DATA_WIDTH  data bus width (32)
//   ADDR_WIDTH  byte-address width
//   DEPTH_LOG2  log2 of the number of words in the array
//   RD_LATENCY  cycles from AR handshake to rvalid (1..15)
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   araddr/arvalid/arready           read address channel
//   rdata/rresp/rvalid/rready        read data channel (rresp 00 OKAY, 10 SLVERR)
//   awaddr/awvalid/awready           write address channel
//   wdata/wstrb/wvalid/wready        write data channel, wstrb[i] enables byte i
//   bresp/bvalid/bready              write response channel
//
// Optional feature (macro RAND_DELAY_EN): an 8-bit LFSR (taps 8,6,5,4, seed
// 8'hA5) replaces RD_LATENCY with a per-read latency of 1+lfsr[2:0] cycles.
// ---------------------------------------------------------------------------
module axil_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_LOG2 = 12,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready
);

  localparam int         DEPTH       = 1 << DEPTH_LOG2;
  localparam int         NUM_BYTES   = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } r_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Any address bit above the word index makes the access out of range.
  function automatic logic addr_oor(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >> (DEPTH_LOG2 + 2)) != '0;
  endfunction

  // Byte-lane bits are ignored: every access returns or updates the aligned word.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{araddr[1:0], awaddr[1:0]};

  // -------------------------------------------------------------------------
  // Read latency source
  // -------------------------------------------------------------------------
  logic [3:0] rd_lat;

`ifdef RAND_DELAY_EN
  localparam int unused_rd_latency = RD_LATENCY;

  logic [7:0] lfsr;

  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values of its sources, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign rd_lat = 4'd1 + {1'b0, lfsr[2:0]};
`else
  assign rd_lat = 4'(RD_LATENCY);
`endif

  // -------------------------------------------------------------------------
  // Read FSM
  // -------------------------------------------------------------------------
  r_state_t              r_state;
  r_state_t              r_next;
  logic [3:0]            rd_cnt;
  logic [DEPTH_LOG2-1:0] ar_idx_q;
  logic                  ar_oor_q;
  logic                  ar_hs;
  logic                  rd_sample;

  assign arready   = (r_state == R_IDLE);
  assign rvalid    = (r_state == R_RESP);
  assign ar_hs     = arvalid && arready;
  // The counter is loaded with the latency; the edge that takes it to zero
  // is the edge that captures the array word.
  assign rd_sample = (r_state == R_WAIT) && (rd_cnt == 4'd1);

`ifndef RAND_DELAY_EN
  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values of its sources, independent of block order.
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= r_next;
    end
  end

  // NOTE: r_next gets its default before the case so that no path through
  // this block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (arvalid)   r_next = R_WAIT;
      R_WAIT:  if (rd_sample) r_next = R_RESP;
      R_RESP:  if (rready)    r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt   <= '0;
      ar_idx_q <= '0;
      ar_oor_q <= 1'b0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        rd_cnt   <= rd_lat;
        ar_idx_q <= araddr[DEPTH_LOG2+1:2];
        ar_oor_q <= addr_oor(araddr);
      end else if (r_state == R_WAIT) begin
        rd_cnt <= rd_cnt - 4'd1;
      end

      // rdata/rresp only change on the sample edge, so they stay stable for
      // the whole R_RESP phase regardless of how long rready is withheld.
      if (rd_sample) begin
        rdata <= ar_oor_q ? '0 : mem[ar_idx_q];
        rresp <= ar_oor_q ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Write path
  // -------------------------------------------------------------------------
  logic                  aw_got;
  logic                  w_got;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  wr_commit;
  logic [DEPTH_LOG2-1:0] aw_idx_q;
  logic                  aw_oor_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [NUM_BYTES-1:0]  w_strb_q;

  assign awready   = !aw_got && !bvalid;
  assign wready    = !w_got && !bvalid;
  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign wr_commit = aw_got && w_got;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      aw_idx_q <= '0;
      aw_oor_q <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
    end else begin
      if (bvalid && bready) begin
        bvalid <= 1'b0;
      end

      // Both flags set implies bvalid is low and neither channel is ready,
      // so the commit never overlaps a handshake or a pending response.
      if (wr_commit) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        bvalid <= 1'b1;
        bresp  <= aw_oor_q ? RESP_SLVERR : RESP_OKAY;
      end else begin
        if (aw_hs) begin
          aw_got   <= 1'b1;
          aw_idx_q <= awaddr[DEPTH_LOG2+1:2];
          aw_oor_q <= addr_oor(awaddr);
        end
        if (w_hs) begin
          w_got    <= 1'b1;
          w_data_q <= wdata;
          w_strb_q <= wstrb;
        end
      end
    end
  end

  // NOTE: the array deliberately has no reset; clearing thousands of words
  // is not possible in one edge and would prevent mapping onto block RAM.
  // A read sampling the same word on the commit edge sees the old contents.
  always_ff @(posedge clk) begin
    if (wr_commit && !aw_oor_q) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (w_strb_q[i]) begin
          mem[aw_idx_q][8*i +: 8] <= w_data_q[8*i +: 8];
        end
      end
    end
  end

endmodule
